// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem memory controller slice.
// Holds region decode defaults, timer register word offsets, FSM state
// encoding and a byte-merge helper used for strobed register writes.
package iomem_pkg;

  localparam logic [31:0] RAM_BASE_DEF   = 32'h4000_0000;
  localparam logic [31:0] RAM_MASK_DEF   = 32'h000F_FFFF;
  localparam logic [31:0] TIMER_BASE_DEF = 32'h3000_0000;
  localparam logic [31:0] ERR_RDATA_DEF  = 32'hDEAD_BEEF;

  // Timer word select, taken from addr[3:2]
  localparam logic [1:0] TMR_MTIME_LO = 2'd0;
  localparam logic [1:0] TMR_MTIME_HI = 2'd1;
  localparam logic [1:0] TMR_CMP_LO   = 2'd2;
  localparam logic [1:0] TMR_CMP_HI   = 2'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RAM_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP     = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_RAM_WAIT = ST_RAM_WAIT,
    S_RESP     = ST_RESP,
    S_DONE     = ST_DONE
  } state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_timer.sv
// 64-bit machine timer: free-running mtime, mtimecmp, byte-strobed writes,
// combinational read mux and a registered mtime >= mtimecmp interrupt.
// Ports:
//   clk_i, rst_n    clock, synchronous active-low reset
//   i_we            write this cycle (already qualified by decode/acceptance)
//   i_sel           word select (addr[3:2])
//   i_wdata/i_wstrb write data and byte strobes
//   o_rdata         word selected by i_sel, current value
//   o_irq           registered compare result
module iomem_timer
  import iomem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_irq;

  always_comb begin
    o_rdata = '0;
    case (i_sel)
      TMR_MTIME_LO: o_rdata = r_mtime[31:0];
      TMR_MTIME_HI: o_rdata = r_mtime[63:32];
      TMR_CMP_LO:   o_rdata = r_mtimecmp[31:0];
      TMR_CMP_HI:   o_rdata = r_mtimecmp[63:32];
      default:      o_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= (r_mtime >= r_mtimecmp);
      // A write to either mtime half freezes the whole counter for that
      // cycle: only the written bytes change, no increment is applied.
      if (i_we && i_sel == TMR_MTIME_LO)
        r_mtime[31:0] <= byte_merge(r_mtime[31:0], i_wdata, i_wstrb);
      else if (i_we && i_sel == TMR_MTIME_HI)
        r_mtime[63:32] <= byte_merge(r_mtime[63:32], i_wdata, i_wstrb);
      else
        r_mtime <= r_mtime + 64'd1;
      if (i_we && i_sel == TMR_CMP_LO)
        r_mtimecmp[31:0] <= byte_merge(r_mtimecmp[31:0], i_wdata, i_wstrb);
      if (i_we && i_sel == TMR_CMP_HI)
        r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], i_wdata, i_wstrb);
    end
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/iomem_mem_ctrl.sv
// iomem slave in front of the main-memory BRAM. Decodes RAM (with
// programmable read/write latency), a 64-bit machine timer, and an
// unmapped region that returns an error response. One transaction at a time.
// Ports:
//   clk_i, rst_n                   clock, synchronous active-low reset
//   iomem_valid/ready              request / one-cycle response pulse
//   iomem_wstrb/addr/wdata/rdata   request fields, response data
//   ram_addr_o/wdata_o/wstrb_o     BRAM word address, write data, byte enables
//   ram_rd_en_o, ram_rdata_i       BRAM read enable, 1-cycle read data
//   timer_irq_o                    mtime >= mtimecmp (registered)
//   bus_err_o, bus_err_sticky_o    unmapped-access pulse and sticky flag
//
// state    | meaning
// IDLE     | waiting for iomem_valid; timer/unmapped accesses done here
// RAM_WAIT | RAM access in flight, counting latency
// RESP     | iomem_ready high for one cycle
// DONE     | dead cycle so a held valid is not accepted twice
module iomem_mem_ctrl
  import iomem_pkg::*;
#(
  parameter logic [31:0] RAM_BASE_ADDR   = RAM_BASE_DEF,
  parameter logic [31:0] RAM_MASK_ADDR   = RAM_MASK_DEF,
  parameter int unsigned RAM_AW          = 17,
  parameter int unsigned RD_LATENCY      = 16,
  parameter int unsigned WR_LATENCY      = 16,
  parameter logic [31:0] TIMER_BASE_ADDR = TIMER_BASE_DEF,
  parameter logic [31:0] ERR_RDATA       = ERR_RDATA_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic [3:0]        ram_wstrb_o,
  output logic              ram_rd_en_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              timer_irq_o,
  output logic              bus_err_o,
  output logic              bus_err_sticky_o
);

  // Counter is 0 in T1, so reaching LAT-1 on the next edge means it
  // currently holds LAT-2.
  localparam logic [7:0] RD_LAST = 8'(RD_LATENCY - 2);
  localparam logic [7:0] WR_LAST = 8'((WR_LATENCY >= 2) ? (WR_LATENCY - 2) : 0);

  state_e            r_state;
  logic [7:0]        r_cnt;
  logic              r_is_wr;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_ram_wstrb;
  logic              r_rd_en;
  logic              r_ready;
  logic [31:0]       r_rdata;
  logic              r_rd_pass;
  logic              r_err;
  logic              r_err_sticky;

  logic        w_ram_hit;
  logic        w_tmr_hit;
  logic        w_is_wr;
  logic        w_tmr_we;
  logic [31:0] w_tmr_rdata;

  assign w_ram_hit = (iomem_addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR;
  assign w_tmr_hit = (iomem_addr[31:4] == TIMER_BASE_ADDR[31:4]) && !w_ram_hit;
  assign w_is_wr   = (iomem_wstrb != 4'b0000);
  assign w_tmr_we  = (r_state == S_IDLE) && iomem_valid && w_tmr_hit && w_is_wr;

  iomem_timer u_timer (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .i_we    (w_tmr_we),
    .i_sel   (iomem_addr[3:2]),
    .i_wdata (iomem_wdata),
    .i_wstrb (iomem_wstrb),
    .o_rdata (w_tmr_rdata),
    .o_irq   (timer_irq_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_is_wr      <= 1'b0;
      r_ram_addr   <= '0;
      r_wdata      <= '0;
      r_ram_wstrb  <= '0;
      r_rd_en      <= 1'b0;
      r_ready      <= 1'b0;
      r_rdata      <= '0;
      r_rd_pass    <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_ready     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_ram_wstrb <= '0;
      r_err       <= 1'b0;
      r_rd_pass   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iomem_valid) begin
            if (w_ram_hit) begin
              r_ram_addr <= iomem_addr[RAM_AW+1:2];
              r_wdata    <= iomem_wdata;
              r_is_wr    <= w_is_wr;
              r_cnt      <= '0;
              if (w_is_wr) begin
                r_ram_wstrb <= iomem_wstrb;
                r_rdata     <= '0;
                if (WR_LATENCY == 1) begin
                  r_ready <= 1'b1;
                  r_state <= S_RESP;
                end else begin
                  r_state <= S_RAM_WAIT;
                end
              end else begin
                r_rd_en <= 1'b1;
                r_state <= S_RAM_WAIT;
              end
            end else if (w_tmr_hit) begin
              r_rdata <= w_is_wr ? 32'h0 : w_tmr_rdata;
              r_ready <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_rdata      <= w_is_wr ? 32'h0 : ERR_RDATA;
              r_err        <= 1'b1;
              r_err_sticky <= 1'b1;
              r_ready      <= 1'b1;
              r_state      <= S_RESP;
            end
          end
        end
        S_RAM_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          // BRAM data is valid during T2 (counter = 1)
          if (!r_is_wr && r_cnt == 8'd1) r_rdata <= ram_rdata_i;
          if (r_cnt == (r_is_wr ? WR_LAST : RD_LAST)) begin
            r_ready <= 1'b1;
            // With a 2-cycle read, ready falls in T2 itself, before the
            // capture edge, so the BRAM output is passed straight through.
            r_rd_pass <= !r_is_wr && (r_cnt == 8'd0);
            r_state   <= S_RESP;
          end
        end
        S_RESP: r_state <= S_DONE;
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end

  assign iomem_ready      = r_ready;
  assign iomem_rdata      = r_rd_pass ? ram_rdata_i : r_rdata;
  assign ram_addr_o       = r_ram_addr;
  assign ram_wdata_o      = r_wdata;
  assign ram_wstrb_o      = r_ram_wstrb;
  assign ram_rd_en_o      = r_rd_en;
  assign bus_err_o        = r_err;
  assign bus_err_sticky_o = r_err_sticky;

endmodule

// File: tb/tb_iomem_mem_ctrl.sv
module tb_iomem_mem_ctrl;
  localparam int RD_LAT = 16;
  localparam int WR_LAT = 4;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic [16:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_wstrb_o;
  logic        ram_rd_en_o;
  logic [31:0] ram_rdata_i = 32'h0;
  logic        timer_irq_o;
  logic        bus_err_o;
  logic        bus_err_sticky_o;

  always #5 clk_i = ~clk_i;

  iomem_mem_ctrl #(
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clk_i            (clk_i),
    .rst_n            (rst_n),
    .iomem_valid      (iomem_valid),
    .iomem_ready      (iomem_ready),
    .iomem_wstrb      (iomem_wstrb),
    .iomem_addr       (iomem_addr),
    .iomem_wdata      (iomem_wdata),
    .iomem_rdata      (iomem_rdata),
    .ram_addr_o       (ram_addr_o),
    .ram_wdata_o      (ram_wdata_o),
    .ram_wstrb_o      (ram_wstrb_o),
    .ram_rd_en_o      (ram_rd_en_o),
    .ram_rdata_i      (ram_rdata_i),
    .timer_irq_o      (timer_irq_o),
    .bus_err_o        (bus_err_o),
    .bus_err_sticky_o (bus_err_sticky_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mt_n  = 0;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int          exp_rd_cyc = -1;
  int          exp_wr_cyc = -1;
  logic [16:0] exp_ram_addr = '0;
  logic [3:0]  exp_wstrb = '0;
  logic [31:0] exp_wdata = '0;

  // BRAM model: 1-cycle synchronous read, byte writes, small aliased array
  logic [31:0] mem [0:255];
  logic        mem_loaded = 1'b0;
  always @(posedge clk_i) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]     <= 32'h1234_5678;
      mem_loaded <= 1'b1;
    end else begin
      if (ram_rd_en_o) ram_rdata_i <= mem[ram_addr_o[7:0]];
      for (int b = 0; b < 4; b++)
        if (ram_wstrb_o[b]) mem[ram_addr_o[7:0]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end

  always @(posedge clk_i) begin
    cyc  <= cyc + 1;
    mt_n <= (!rst_n) ? 0 : mt_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (iomem_ready) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ready", 64'(iomem_ready), 64'(1'b0));
      end else begin
        e = sb_q.pop_front();
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        chk("rdata", 64'(iomem_rdata), 64'(e.rdata));
        chk("bus_err", 64'(bus_err_o), 64'(e.err));
      end
    end
    if (bus_err_o && !iomem_ready) chk("err_without_ready", 64'(iomem_ready), 64'(1'b1));
    if (ram_rd_en_o) begin
      chk("rd_en_cycle", 64'(cyc), 64'(exp_rd_cyc));
      chk("rd_addr", 64'(ram_addr_o), 64'(exp_ram_addr));
      exp_rd_cyc = -1;
    end
    if (ram_wstrb_o !== 4'b0000) begin
      chk("wr_cycle", 64'(cyc), 64'(exp_wr_cyc));
      chk("wr_strb", 64'(ram_wstrb_o), 64'(exp_wstrb));
      chk("wr_data", 64'(ram_wdata_o), 64'(exp_wdata));
      chk("wr_addr", 64'(ram_addr_o), 64'(exp_ram_addr));
      exp_wr_cyc = -1;
    end
  end

  task automatic txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input int lat, input logic exp_err,
                     input int hold);
    exp_t e;
    @(negedge clk_i);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = ws;
    iomem_wdata = wd;
    e.cyc = cyc + lat;
    e.rdata = exp_rd;
    e.err = exp_err;
    sb_q.push_back(e);
    if ((a & ~32'h000F_FFFF) == 32'h4000_0000) begin
      exp_ram_addr = a[18:2];
      if (ws == 4'h0) exp_rd_cyc = cyc + 1;
      else begin
        exp_wr_cyc = cyc + 1;
        exp_wstrb  = ws;
        exp_wdata  = wd;
      end
    end
    repeat (hold) @(negedge clk_i);
    iomem_valid = 1'b0;
    iomem_addr  = 32'h3000_0000;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'h5555_5555;
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk_i);
    chk("resp_timeout", 64'(sb_q.size()), 64'(0));
    sb_q.delete();
    repeat (2) @(negedge clk_i);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", 64'(iomem_ready), 64'(1'b0));
    chk("rst_rd_en", 64'(ram_rd_en_o), 64'(1'b0));
    chk("rst_wstrb", 64'(ram_wstrb_o), 64'(4'h0));
    chk("rst_err", 64'(bus_err_o), 64'(1'b0));
    chk("rst_rdata", 64'(iomem_rdata), 64'(32'h0));
    chk("rst_sticky", 64'(bus_err_sticky_o), 64'(1'b0));
    chk("rst_irq", 64'(timer_irq_o), 64'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_reset_vals();
    rst_n = 1'b1;

    // mtimecmp = 100, then irq window around mtime = 100
    txn(32'h3000_0008, 4'hF, 32'd100, 32'h0, 1, 1'b0, 1);
    txn(32'h3000_000C, 4'hF, 32'h0, 32'h0, 1, 1'b0, 1);
    txn(32'h3000_0008, 4'h0, 32'h0, 32'd100, 1, 1'b0, 1);
    for (int i = 0; i < 1000 && mt_n < 90; i++) @(negedge clk_i);
    for (int k = 0; k < 21; k++) begin
      chk("irq", 64'(timer_irq_o), 64'(mt_n >= 101));
      @(negedge clk_i);
    end

    // byte-strobed mtimecmp write
    txn(32'h3000_000C, 4'b0010, 32'h1234_AB56, 32'h0, 1, 1'b0, 1);
    txn(32'h3000_000C, 4'h0, 32'h0, 32'h0000_AB00, 1, 1'b0, 1);

    // carry from mtime low into high half
    txn(32'h3000_0004, 4'hF, 32'h0, 32'h0, 1, 1'b0, 1);
    txn(32'h3000_0000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, 1);
    txn(32'h3000_0004, 4'h0, 32'h0, 32'h0000_0001, 1, 1'b0, 1);

    // RAM read, write with valid held through DONE, read-back, top of window
    txn(32'h4000_0010, 4'h0, 32'h0, 32'h1234_5678, RD_LAT, 1'b0, 1);
    txn(32'h4000_0010, 4'b0101, 32'hAABB_CCDD, 32'h0, WR_LAT, 1'b0, WR_LAT + 2);
    txn(32'h4000_0010, 4'h0, 32'h0, 32'h12BB_56DD, RD_LAT, 1'b0, 1);
    txn(32'h400F_FFFC, 4'h0, 32'h0, 32'h0, RD_LAT, 1'b0, 1);

    // unmapped: below regions, just past timer window, just past RAM window
    chk("sticky_before", 64'(bus_err_sticky_o), 64'(1'b0));
    txn(32'h1000_0000, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 1);
    chk("sticky_set", 64'(bus_err_sticky_o), 64'(1'b1));
    txn(32'h3000_0010, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 1);
    txn(32'h4010_0000, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 1);
    txn(32'h3000_0008, 4'h0, 32'h0, 32'd100, 1, 1'b0, 1);
    chk("sticky_hold", 64'(bus_err_sticky_o), 64'(1'b1));

    // reset at T0+5 of a RAM read aborts it
    @(negedge clk_i);
    iomem_valid  = 1'b1;
    iomem_addr   = 32'h4000_0010;
    iomem_wstrb  = 4'h0;
    c0           = cyc;
    exp_rd_cyc   = c0 + 1;
    exp_ram_addr = 17'd4;
    @(negedge clk_i);
    iomem_valid = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_n = 1'b0;
    @(negedge clk_i);
    chk_reset_vals();
    rst_n = 1'b1;
    repeat (25) @(negedge clk_i);
    chk("abort_no_resp", 64'(sb_q.size()), 64'(0));
    txn(32'h4000_0010, 4'h0, 32'h0, 32'h12BB_56DD, RD_LAT, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
